// File: rtl/pong_pixel_engine_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_pixel_engine_if : timing, object and colour bundle for the renderer
// Rev 1.0
// ---------------------------------------------------------------------------
interface pong_pixel_engine_if #(
  parameter int COLOR_W = 4
);
  logic [11:0]        h_cnt;
  logic [11:0]        v_cnt;
  logic               enable;
  logic [11:0]        paddle1;
  logic [11:0]        paddle2;
  logic [11:0]        ball_x;
  logic [11:0]        ball_y;
  logic               goal_pulse;
  logic               goal_side;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               flashing;

  modport master (
    output h_cnt, v_cnt, enable, paddle1, paddle2, ball_x, ball_y,
           goal_pulse, goal_side,
    input  red, green, blue, flashing
  );

  modport slave (
    input  h_cnt, v_cnt, enable, paddle1, paddle2, ball_x, ball_y,
           goal_pulse, goal_side,
    output red, green, blue, flashing
  );
endinterface
`default_nettype wire

// File: rtl/pong_pixel_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_pixel_engine : 2-stage registered Pong renderer with goal-flash FSM
// Rev 1.0
// ---------------------------------------------------------------------------
module pong_pixel_engine #(
  parameter int H_OFFSET     = 144,
  parameter int V_OFFSET     = 35,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BORDER       = 10,
  parameter int PADDLE_LEN   = 50,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_INSET = 40,
  parameter int BALL_SIZE    = 10,
  parameter int COLOR_W      = 4,
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_LOG2   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  pong_pixel_engine_if.slave bus
);

  localparam logic [12:0] X0       = 13'(H_OFFSET);
  localparam logic [12:0] Y0       = 13'(V_OFFSET);
  localparam logic [12:0] BORDER_L = 13'(H_OFFSET + BORDER);
  localparam logic [12:0] BORDER_R = 13'(H_OFFSET + H_ACTIVE - BORDER);
  localparam logic [12:0] BORDER_T = 13'(V_OFFSET + BORDER);
  localparam logic [12:0] BORDER_B = 13'(V_OFFSET + V_ACTIVE - BORDER);
  localparam logic [12:0] MID_X    = 13'(H_OFFSET + H_ACTIVE / 2);
  localparam logic [12:0] SERVE_L  = 13'(H_OFFSET + H_ACTIVE / 2 - BORDER / 2);
  localparam logic [12:0] SERVE_R  = 13'(H_OFFSET + H_ACTIVE / 2 + BORDER / 2);
  localparam logic [12:0] LPAD_L   = 13'(H_OFFSET + PADDLE_INSET);
  localparam logic [12:0] LPAD_R   = 13'(H_OFFSET + PADDLE_INSET + PADDLE_W);
  localparam logic [12:0] RPAD_L   = 13'(H_OFFSET + H_ACTIVE - PADDLE_INSET - PADDLE_W);
  localparam logic [12:0] RPAD_R   = 13'(H_OFFSET + H_ACTIVE - PADDLE_INSET);
  localparam logic [12:0] PAD_LEN  = 13'(PADDLE_LEN);
  localparam logic [12:0] BALL_SZ  = 13'(BALL_SIZE);
  localparam logic [7:0]  FLASH_END = 8'(FLASH_FRAMES);
  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

  typedef enum logic [0:0] {IDLE = 1'b0, FLASH = 1'b1} state_t;

  logic        frame_start;
  logic [12:0] h, v, p1_top, p2_top, ball_left, ball_top;
  logic [11:0] p1_q, p1_d, p2_q, p2_d, bx_q, bx_d, by_q, by_d;
  logic        ball_hit_q, ball_hit_d, paddle_hit_q, paddle_hit_d;
  logic        serve_hit_q, serve_hit_d, border_hit_q, border_hit_d;
  logic        left_half_q, left_half_d, en_q, en_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  state_t      state_q;
  logic [7:0]  frame_cnt_q;
  logic        side_q, flashing_q, flash_on, conceding;

  assign frame_start = (bus.h_cnt == 12'd0) && (bus.v_cnt == 12'd0);

  always_comb begin
    h         = {1'b0, bus.h_cnt};
    v         = {1'b0, bus.v_cnt};
    p1_d      = frame_start ? bus.paddle1 : p1_q;
    p2_d      = frame_start ? bus.paddle2 : p2_q;
    bx_d      = frame_start ? bus.ball_x  : bx_q;
    by_d      = frame_start ? bus.ball_y  : by_q;
    p1_top    = Y0 + {1'b0, p1_q};
    p2_top    = Y0 + {1'b0, p2_q};
    ball_left = X0 + {1'b0, bx_q};
    ball_top  = Y0 + {1'b0, by_q};

    border_hit_d = (h < BORDER_L) || (h >= BORDER_R) || (v < BORDER_T) || (v >= BORDER_B);
    serve_hit_d  = (h >= SERVE_L) && (h < SERVE_R);
    paddle_hit_d = ((h >= LPAD_L) && (h < LPAD_R) && (v >= p1_top) && (v < p1_top + PAD_LEN))
                || ((h >= RPAD_L) && (h < RPAD_R) && (v >= p2_top) && (v < p2_top + PAD_LEN));
    ball_hit_d   = (h >= ball_left) && (h < ball_left + BALL_SZ)
                && (v >= ball_top) && (v < ball_top + BALL_SZ);
    left_half_d  = (h < MID_X);
    en_d         = bus.enable;
  end

  // Flash-on is the first half of each blink period; the conceding half turns red.
  assign flash_on  = (state_q == FLASH) && !frame_cnt_q[BLINK_LOG2];
  assign conceding = side_q ? !left_half_q : left_half_q;

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (en_q) begin
      if (ball_hit_q || paddle_hit_q || serve_hit_q) begin
        red_d   = FULL;
        green_d = FULL;
        blue_d  = FULL;
      end else if (border_hit_q) begin
        red_d = FULL;
        if (!(flash_on && conceding)) begin
          green_d = FULL;
          blue_d  = FULL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q         <= '0;
      p2_q         <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      ball_hit_q   <= 1'b0;
      paddle_hit_q <= 1'b0;
      serve_hit_q  <= 1'b0;
      border_hit_q <= 1'b0;
      left_half_q  <= 1'b0;
      en_q         <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
    end else begin
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      ball_hit_q   <= ball_hit_d;
      paddle_hit_q <= paddle_hit_d;
      serve_hit_q  <= serve_hit_d;
      border_hit_q <= border_hit_d;
      left_half_q  <= left_half_d;
      en_q         <= en_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  // goal_pulse has priority over the frame tick, so a coincident frame_start leaves frame_cnt at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      side_q      <= 1'b0;
      flashing_q  <= 1'b0;
    end else if (bus.goal_pulse) begin
      state_q     <= FLASH;
      frame_cnt_q <= 8'd0;
      side_q      <= bus.goal_side;
      flashing_q  <= 1'b1;
    end else if ((state_q == FLASH) && frame_start) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
      if (frame_cnt_q + 8'd1 == FLASH_END) begin
        state_q    <= IDLE;
        flashing_q <= 1'b0;
      end
    end
  end

  assign bus.red      = red_q;
  assign bus.green    = green_q;
  assign bus.blue     = blue_q;
  assign bus.flashing = flashing_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_pixel_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pong_pixel_engine : directed bench for the registered Pong renderer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pong_pixel_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] BLACK = 12'h000;

  pong_pixel_engine_if #(.COLOR_W(4)) bus ();

  pong_pixel_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic get_pix(input logic [11:0] h, input logic [11:0] v, input logic en,
                         output logic [11:0] rgb);
    bus.h_cnt  = h;
    bus.v_cnt  = v;
    bus.enable = en;
    @(posedge clk);
    @(posedge clk);
    #1;
    rgb = {bus.red, bus.green, bus.blue};
  endtask

  task automatic frame_pulse();
    bus.h_cnt  = 12'd0;
    bus.v_cnt  = 12'd0;
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    bus.h_cnt = 12'd1;
    bus.v_cnt = 12'd1;
  endtask

  task automatic goal(input logic side);
    bus.goal_side  = side;
    bus.goal_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.goal_pulse = 1'b0;
    total++;
    if (bus.flashing !== 1'b1) begin
      bad++;
      $display("FAIL goal_flashing side=%0d: got %b want 1", side, bus.flashing);
    end
  endtask

  task automatic test_reset();
    logic [11:0] rgb;
    rst_n          = 1'b0;
    bus.h_cnt      = 12'd1;
    bus.v_cnt      = 12'd1;
    bus.enable     = 1'b0;
    bus.paddle1    = 12'd200;
    bus.paddle2    = 12'd200;
    bus.ball_x     = 12'd100;
    bus.ball_y     = 12'd200;
    bus.goal_pulse = 1'b0;
    bus.goal_side  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rgb = {bus.red, bus.green, bus.blue};
    total++;
    if (rgb !== BLACK || bus.flashing !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rgb=%h flashing=%b want 000/0", rgb, bus.flashing);
    end
    rst_n = 1'b1;
    // No frame_start yet, so paddles still sit at shadow row 0.
    get_pix(12'd190, 12'd60, 1'b1, rgb);
    total++;
    if (rgb !== WHITE) begin bad++; $display("FAIL reset_lpaddle_shadow: got %h want %h", rgb, WHITE); end
    get_pix(12'd740, 12'd60, 1'b1, rgb);
    total++;
    if (rgb !== WHITE) begin bad++; $display("FAIL reset_rpaddle_shadow: got %h want %h", rgb, WHITE); end
    get_pix(12'd300, 12'd300, 1'b1, rgb);
    total++;
    if (rgb !== BLACK) begin bad++; $display("FAIL reset_background: got %h want %h", rgb, BLACK); end
  endtask

  task automatic test_latency();
    logic [11:0] rgb, exp;
    int hh;
    frame_pulse();
    for (int i = 0; i <= 13; i++) begin
      if (i < 13) begin
        bus.h_cnt  = 12'(243 + i);
        bus.v_cnt  = 12'd235;
        bus.enable = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        hh  = 243 + i - 1;
        exp = (hh >= 244 && hh <= 253) ? WHITE : BLACK;
        rgb = {bus.red, bus.green, bus.blue};
        total++;
        if (rgb !== exp) begin
          bad++;
          $display("FAIL latency_ball h=%0d: got %h want %h", hh, rgb, exp);
        end
      end
    end
  endtask

  task automatic test_shadow();
    logic [11:0] rgb;
    bus.ball_y = 12'd280;
    frame_pulse();
    bus.ball_x = 12'd300;
    get_pix(12'd250, 12'd320, 1'b1, rgb);
    total++;
    if (rgb !== WHITE) begin bad++; $display("FAIL shadow_old_at_100: got %h want %h", rgb, WHITE); end
    get_pix(12'd450, 12'd320, 1'b1, rgb);
    total++;
    if (rgb !== BLACK) begin bad++; $display("FAIL shadow_new_early: got %h want %h", rgb, BLACK); end
    frame_pulse();
    get_pix(12'd250, 12'd320, 1'b1, rgb);
    total++;
    if (rgb !== BLACK) begin bad++; $display("FAIL shadow_old_gone: got %h want %h", rgb, BLACK); end
    get_pix(12'd450, 12'd320, 1'b1, rgb);
    total++;
    if (rgb !== WHITE) begin bad++; $display("FAIL shadow_new_at_300: got %h want %h", rgb, WHITE); end
  endtask

  task automatic test_enable();
    logic [11:0] rgb;
    logic [11:0] hs [8];
    hs = '{12'd144, 12'd150, 12'd200, 12'd300, 12'd459, 12'd500, 12'd700, 12'd783};
    for (int i = 0; i < 8; i++) begin
      get_pix(hs[i], 12'd40, 1'b0, rgb);
      total++;
      if (rgb !== BLACK) begin
        bad++;
        $display("FAIL enable_low h=%0d: got %h want %h", hs[i], rgb, BLACK);
      end
    end
    get_pix(12'd300, 12'd40, 1'b1, rgb);
    total++;
    if (rgb !== WHITE) begin bad++; $display("FAIL enable_high_border: got %h want %h", rgb, WHITE); end
  endtask

  task automatic test_flash();
    logic [11:0] rgb, exp;
    goal(1'b0);
    for (int f = 0; f < 30; f++) begin
      exp = ((f & 8) != 0) ? WHITE : RED;
      get_pix(12'd150, 12'd100, 1'b1, rgb);
      total++;
      if (rgb !== exp) begin bad++; $display("FAIL flash_left f=%0d: got %h want %h", f, rgb, exp); end
      get_pix(12'd778, 12'd100, 1'b1, rgb);
      total++;
      if (rgb !== WHITE) begin bad++; $display("FAIL flash_right f=%0d: got %h want %h", f, rgb, WHITE); end
      total++;
      if (bus.flashing !== 1'b1) begin bad++; $display("FAIL flash_active f=%0d: got %b want 1", f, bus.flashing); end
      frame_pulse();
    end
    total++;
    if (bus.flashing !== 1'b0) begin bad++; $display("FAIL flash_end: got %b want 0", bus.flashing); end
    get_pix(12'd150, 12'd100, 1'b1, rgb);
    total++;
    if (rgb !== WHITE) begin bad++; $display("FAIL flash_idle_left: got %h want %h", rgb, WHITE); end
  endtask

  task automatic test_restart();
    logic [11:0] rgb, exp;
    goal(1'b0);
    repeat (12) frame_pulse();
    get_pix(12'd150, 12'd100, 1'b1, rgb);
    total++;
    if (rgb !== WHITE) begin bad++; $display("FAIL restart_pre_left: got %h want %h", rgb, WHITE); end
    goal(1'b1);
    for (int f = 0; f < 30; f++) begin
      exp = ((f & 8) != 0) ? WHITE : RED;
      get_pix(12'd778, 12'd100, 1'b1, rgb);
      total++;
      if (rgb !== exp) begin bad++; $display("FAIL restart_right f=%0d: got %h want %h", f, rgb, exp); end
      get_pix(12'd150, 12'd100, 1'b1, rgb);
      total++;
      if (rgb !== WHITE) begin bad++; $display("FAIL restart_left f=%0d: got %h want %h", f, rgb, WHITE); end
      total++;
      if (bus.flashing !== 1'b1) begin bad++; $display("FAIL restart_active f=%0d: got %b want 1", f, bus.flashing); end
      frame_pulse();
    end
    total++;
    if (bus.flashing !== 1'b0) begin bad++; $display("FAIL restart_end: got %b want 0", bus.flashing); end
  endtask

  task automatic test_async_reset();
    logic [11:0] rgb;
    goal(1'b0);
    frame_pulse();
    frame_pulse();
    get_pix(12'd300, 12'd40, 1'b1, rgb);
    total++;
    if (rgb !== RED) begin bad++; $display("FAIL areset_pre_red: got %h want %h", rgb, RED); end
    #2;
    rst_n = 1'b0;
    #1;
    rgb = {bus.red, bus.green, bus.blue};
    total++;
    if (rgb !== BLACK || bus.flashing !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate: got rgb=%h flashing=%b want 000/0", rgb, bus.flashing);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    get_pix(12'd740, 12'd60, 1'b1, rgb);
    total++;
    if (rgb !== WHITE) begin bad++; $display("FAIL areset_rpaddle_shadow: got %h want %h", rgb, WHITE); end
    get_pix(12'd450, 12'd320, 1'b1, rgb);
    total++;
    if (rgb !== BLACK) begin bad++; $display("FAIL areset_ball_shadow: got %h want %h", rgb, BLACK); end
    get_pix(12'd300, 12'd40, 1'b1, rgb);
    total++;
    if (rgb !== WHITE || bus.flashing !== 1'b0) begin
      bad++;
      $display("FAIL areset_idle_border: got rgb=%h flashing=%b want fff/0", rgb, bus.flashing);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_shadow();
    test_enable();
    test_flash();
    test_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pong_pixel_engine.md
# pong_pixel_engine

Registered, parametrised pixel generator for the Pong display path. It sits between the VGA timing counters and the DAC pins and replaces the combinational renderer. Object positions are snapshotted once per frame, so a mid-frame move cannot tear the image. Pixel colour comes out of a fixed 2-cycle pipeline. A goal-flash state machine blinks one half of the border for a programmable number of frames after each point.

## Interface
Parameters:
- H_OFFSET, 144, first active column in h_cnt units (sync + back porch)
- V_OFFSET, 35, first active row in v_cnt units
- H_ACTIVE, 640, active width in pixels
- V_ACTIVE, 480, active height in pixels
- BORDER, 10, border and serving-line thickness in pixels
- PADDLE_LEN, 50, paddle height in pixels
- PADDLE_W, 10, paddle width in pixels
- PADDLE_INSET, 40, gap between the screen edge and the paddle's outer face
- BALL_SIZE, 10, ball side in pixels
- COLOR_W, 4, bits per colour channel
- FLASH_FRAMES, 30, number of frames a goal flash lasts (1..255)
- BLINK_LOG2, 3, blink half-period is 2^BLINK_LOG2 frames

Ports (reset is asynchronous and active-low):
- clk  in  1  pixel clock; one h_cnt step per cycle
- rst_n  in  1  asynchronous active-low reset
- h_cnt  in  12  horizontal counter from VGA timing
- v_cnt  in  12  vertical counter from VGA timing
- enable  in  1  high inside the active video area
- paddle1  in  12  left paddle top, active-area rows
- paddle2  in  12  right paddle top, active-area rows
- ball_x  in  12  ball left edge, active-area columns
- ball_y  in  12  ball top edge, active-area rows
- goal_pulse  in  1  one-cycle strobe; a point was scored
- goal_side  in  1  0 = left player conceded, 1 = right player conceded
- red  out  COLOR_W  red channel
- green  out  COLOR_W  green channel
- blue  out  COLOR_W  blue channel
- flashing  out  1  high while the FSM is in FLASH

## Operation
- frame_start is true when h_cnt==0 and v_cnt==0.
- On the clock edge where frame_start is true, paddle1/paddle2/ball_x/ball_y are copied into shadow registers. All geometry uses the shadow values. The shadows reset to 0.
- All region tests are half-open [start, start+size). They are computed in 13 bits so sums cannot wrap.
- Regions, in absolute counter units with X0=H_OFFSET and Y0=V_OFFSET:
  - border: h<X0+BORDER, or h>=X0+H_ACTIVE-BORDER, or v<Y0+BORDER, or v>=Y0+V_ACTIVE-BORDER.
  - serving line: X0+H_ACTIVE/2-BORDER/2 <= h < X0+H_ACTIVE/2+BORDER/2.
  - left paddle: h in [X0+PADDLE_INSET, +PADDLE_W), v in [Y0+p1, +PADDLE_LEN).
  - right paddle: h in [X0+H_ACTIVE-PADDLE_INSET-PADDLE_W, +PADDLE_W), same rows rule using p2.
  - ball: h in [X0+bx, +BALL_SIZE), v in [Y0+by, +BALL_SIZE).
- Colour priority is ball > paddle > serving line > border > background.
  - Background is black.
  - Ball, paddles and serving line are white (all channels all-ones).
  - Border is white, except during a flash-on phase on the conceding half (left half when goal_side=0: h < X0+H_ACTIVE/2). That half is red: red all-ones, green=blue=0.
- enable low forces black. enable travels through the same pipeline as the geometry.
- FSM states:
  - IDLE: flashing=0.
  - goal_pulse moves the FSM to FLASH, latches goal_side and clears frame_cnt (8 bits).
  - In FLASH, frame_cnt increments on each frame_start.
  - The flash-on phase is frame_cnt bit BLINK_LOG2 == 0, so the flash is on first.
  - When frame_cnt reaches FLASH_FRAMES at a frame_start, the FSM returns to IDLE.
  - goal_pulse while in FLASH restarts the flash: frame_cnt is cleared and goal_side is re-latched.
  - If goal_pulse and frame_start occur in the same cycle, goal_pulse wins and frame_cnt is 0.

## Timing
- Stage 1 registers the region hits plus enable. Stage 2 registers the colour mux into red/green/blue.
- Latency from h_cnt/v_cnt/enable to colour is exactly 2 cycles. Downstream must delay hsync/vsync by 2 cycles.
- Shadow registers update at the end of the frame_start cycle. The first pixel that uses the new positions is the frame_start pixel + 1 cycle of input, seen at the output 2 cycles later.
- flashing is registered and asserts 1 cycle after goal_pulse.
- On reset:
  - red/green/blue=0, flashing=0, FSM=IDLE, frame_cnt=0, shadows=0, pipeline enable=0.
  - Reset mid-frame gives black until 2 cycles after rst_n deasserts and enable is high.

## Test plan
- Ball at bx=100, by=200, default params; drive h=244..253, v=235: white output at cycles t+2 for those columns, black at h=254. This checks the half-open bound and the 2-cycle latency.
- Change ball_x from 100 to 300 mid-frame at v=300: rows below v=300 still render at bx=100 until the next frame_start, then render at bx=300.
- enable=0 with h inside the border: red/green/blue stay 0 for the whole line.
- goal_pulse with goal_side=0 and FLASH_FRAMES=30:
  - The left border is red in frames 0-7, white in frames 8-15, red in frames 16-23, white in frames 24-29.
  - The right border stays white throughout.
  - flashing drops at the 30th frame_start.
- Second goal_pulse (goal_side=1) at frame 12 of a flash: the right half now flashes, the counter restarts, and the flash lasts 30 more frames.
- Assert rst_n low mid-flash at h=300: outputs go 0 and flashing goes 0 immediately (asynchronously); after release the FSM is IDLE and the shadows are 0.
